dmem_responder: RTL and testbench

Data-side memory responder for the five-stage MIPS core: it is the slave end of the MEM-stage data port, which carries `dce`, `daddr`, `we`, `dre` and `din`. It decodes each request to one of two targets: an internal word-organised data RAM, or three memory-mapped device registers (LED, 7-segment and switch). It performs byte-lane writes and returns registered read data to the write-back stage. A configurable wait-state counter stalls the pipeline for slow-memory emulation.

---
 rtl/dmem_responder_if.sv | 13 +
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage data port between the CPU (master) and the data memory responder (slave).
interface dmem_responder_if;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [3:0]  dre;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dstall;

  modport master (output dce, daddr, we, dre, din, input dout, dstall);
  modport slave  (input dce, daddr, we, dre, din, output dout, dstall);
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus LED/7-segment/switch registers,
// byte-lane writes, registered read data and an optional wait-state sequencer.
module dmem_responder #(
  parameter int          AW          = 12,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] LED_ADDR    = 32'hBFAF_F000,
  parameter logic [31:0] SEG7_ADDR   = 32'hBFAF_F010,
  parameter logic [31:0] SWITCH_ADDR = 32'hBFAF_F020
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  dmem_responder_if.slave bus,
  output logic [15:0]     led,
  output logic [31:0]     seg7,
  input  logic [15:0]     sw_i
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          commit;
  logic [31:0]   dout_q, led_q, seg7_q;
  logic [15:0]   swMeta_q, swSync_q;
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] ramIdx;
  logic          selLed, selSeg7, selSwitch, selRam;
  logic          doWrite, doRead;
  logic [31:0]   targetWord;
  logic [1:0]    unusedByteOffset;

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  lanes);
    logic [31:0] result;
    result = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) result[8*i +: 8] = newWord[8*i +: 8];
    end
    return result;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dce) begin
          if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = bus.dce;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset so a request held across reset never reports a stall.
  assign bus.dstall = !cpu_rst && bus.dce && (WAIT_CYCLES != 0) &&
                      !(state_q == WAIT && cnt_q == 4'd0);

  assign unusedByteOffset = bus.daddr[1:0];

  always_comb begin
    ramIdx    = bus.daddr[AW+1:2];
    selLed    = (bus.daddr[31:2] == LED_ADDR[31:2]);
    selSeg7   = (bus.daddr[31:2] == SEG7_ADDR[31:2]);
    selSwitch = (bus.daddr[31:2] == SWITCH_ADDR[31:2]);
    selRam    = !(selLed || selSeg7 || selSwitch);
    doWrite   = commit && (bus.we != 4'b0000);
    doRead    = commit && (bus.we == 4'b0000) && (bus.dre != 4'b0000);
    if (selLed)         targetWord = led_q;
    else if (selSeg7)   targetWord = seg7_q;
    else if (selSwitch) targetWord = {16'h0000, swSync_q[7:0], swSync_q[15:8]};
    else                targetWord = mem[ramIdx];
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      dout_q <= 32'h0;
    end else if (doRead) begin
      dout_q <= targetWord;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_q  <= 32'h0;
      seg7_q <= 32'h0;
    end else if (doWrite) begin
      if (selLed)  led_q  <= mergeLanes(led_q, bus.din, bus.we);
      if (selSeg7) seg7_q <= mergeLanes(seg7_q, bus.din, bus.we);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      swMeta_q <= 16'h0;
      swSync_q <= 16'h0;
    end else begin
      swMeta_q <= sw_i;
      swSync_q <= swMeta_q;
    end
  end

  // RAM has no reset so it can map onto block RAM with byte enables.
  always_ff @(posedge cpu_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (doWrite && selRam && bus.we[i]) mem[ramIdx][8*i +: 8] <= bus.din[8*i +: 8];
    end
  end

  assign bus.dout = dout_q;
  assign led      = {led_q[23:16], led_q[31:24]};
  assign seg7     = {seg7_q[7:0], seg7_q[15:8], seg7_q[23:16], seg7_q[31:24]};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a three-wait instance checked
// against a behavioural memory/register model.
module tb_dmem_responder;

  localparam logic [31:0] LED_A = 32'hBFAF_F000;
  localparam logic [31:0] SEG_A = 32'hBFAF_F010;
  localparam logic [31:0] SW_A  = 32'hBFAF_F020;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] swIn = 16'h0;
  logic [15:0] led0, led3;
  logic [31:0] seg0, seg3;

  dmem_responder_if bus0 ();
  dmem_responder_if bus3 ();

  dmem_responder #(.AW(12), .WAIT_CYCLES(0)) dut0 (
    .cpu_clk(clk), .cpu_rst(rst), .bus(bus0), .led(led0), .seg7(seg0), .sw_i(swIn));

  dmem_responder #(.AW(12), .WAIT_CYCLES(3)) dut3 (
    .cpu_clk(clk), .cpu_rst(rst), .bus(bus3), .led(led3), .seg7(seg3), .sw_i(swIn));

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model of the zero-wait instance.
  logic [31:0] mem0 [int];
  logic [31:0] led0M = 32'h0;
  logic [31:0] seg0M = 32'h0;
  logic [31:0] dout0M = 32'h0;
  logic [15:0] swVisible = 16'h0;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] withLanes(input logic [31:0] oldW, input logic [31:0] newW,
                                            input logic [3:0] lanes);
    logic [31:0] r;
    r = oldW;
    for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = newW[8*i +: 8];
    return r;
  endfunction

  function automatic void modelStep0(input bit ce, input logic [31:0] a, input logic [3:0] w,
                                     input logic [3:0] r, input logic [31:0] d);
    int key;
    logic [31:0] oldW;
    if (!ce) return;
    key = int'(a[13:2]);
    if (w != 4'b0) begin
      if (a[31:2] == LED_A[31:2]) led0M = withLanes(led0M, d, w);
      else if (a[31:2] == SEG_A[31:2]) seg0M = withLanes(seg0M, d, w);
      else if (a[31:2] != SW_A[31:2]) begin
        oldW = mem0.exists(key) ? mem0[key] : 32'h0;
        mem0[key] = withLanes(oldW, d, w);
      end
    end else if (r != 4'b0) begin
      if (a[31:2] == LED_A[31:2]) dout0M = led0M;
      else if (a[31:2] == SEG_A[31:2]) dout0M = seg0M;
      else if (a[31:2] == SW_A[31:2]) dout0M = {16'h0, swVisible[7:0], swVisible[15:8]};
      else dout0M = mem0.exists(key) ? mem0[key] : 32'h0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle access on the zero-wait instance, mirrored into the model.
  task automatic step0(input bit ce, input logic [31:0] a, input logic [3:0] w,
                       input logic [3:0] r, input logic [31:0] d);
    modelStep0(ce, a, w, r, d);
    bus0.dce = ce; bus0.daddr = a; bus0.we = w; bus0.dre = r; bus0.din = d;
    tick();
    bus0.dce = 1'b0;
  endtask

  // Holds one request on the wait-state instance until dstall drops, then
  // returns how many cycles stalled and whether dout/led moved before commit.
  task automatic run3(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                      input logic [31:0] d, output int stalls, output bit early,
                      output bit timedOut);
    logic [31:0] startDout;
    logic [15:0] startLed;
    bit done;
    bus3.dce = 1'b1; bus3.daddr = a; bus3.we = w; bus3.dre = r; bus3.din = d;
    startDout = bus3.dout;
    startLed = led3;
    stalls = 0; early = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (bus3.dout !== startDout || led3 !== startLed) early = 1;
      if (bus3.dstall === 1'b1) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    bus3.dce = 1'b0;
    timedOut = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.dce = 1'b1; bus0.daddr = 32'h100; bus0.we = 4'hF; bus0.dre = 4'h0; bus0.din = 32'hDEAD_BEEF;
    bus3.dce = 1'b1; bus3.daddr = 32'h100; bus3.we = 4'h0; bus3.dre = 4'hF; bus3.din = 32'h0;
    tick(); tick();
    testsRun++;
    if (bus3.dstall !== 1'b0 || bus0.dstall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_dstall: got %b/%b expected 0/0", bus0.dstall, bus3.dstall);
    end
    testsRun++;
    if (bus0.dout !== 32'h0 || bus3.dout !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_dout: got %h/%h expected 0/0", bus0.dout, bus3.dout);
    end
    testsRun++;
    if (led0 !== 16'h0 || seg0 !== 32'h0 || led3 !== 16'h0 || seg3 !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_regs: got led %h/%h seg %h/%h expected all 0", led0, led3, seg0, seg3);
    end
    bus0.dce = 1'b0; bus3.dce = 1'b0;
    rst = 1'b0;
    led0M = 32'h0; seg0M = 32'h0; dout0M = 32'h0;
    tick();
  endtask

  task automatic test_led();
    logic [31:0] d;
    step0(1, LED_A, 4'hF, 4'h0, 32'hA500_0000);
    testsRun++;
    if (led0 !== 16'h00A5) begin
      testsFailed++;
      $display("[TB] FAIL led_write: got %h expected 00a5", led0);
    end
    step0(1, LED_A, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== 32'hA500_0000) begin
      testsFailed++;
      $display("[TB] FAIL led_read: got %h expected a5000000", bus0.dout);
    end
    d = $urandom;
    step0(1, SEG_A, 4'hF, 4'h0, d);
    testsRun++;
    if (seg0 !== swap32(d)) begin
      testsFailed++;
      $display("[TB] FAIL seg7_write: got %h expected %h", seg0, swap32(d));
    end
    step0(1, SEG_A, 4'h0, 4'h3, 32'h0);
    testsRun++;
    if (bus0.dout !== d) begin
      testsFailed++;
      $display("[TB] FAIL seg7_read: got %h expected %h", bus0.dout, d);
    end
  endtask

  task automatic test_byte_lanes();
    step0(1, 32'h100, 4'hF, 4'h0, 32'h1122_3344);
    step0(1, 32'h100, 4'b1000, 4'h0, 32'hFF00_0000);
    step0(1, 32'h100, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== 32'hFF22_3344) begin
      testsFailed++;
      $display("[TB] FAIL byte_lanes: got %h expected ff223344", bus0.dout);
    end
  endtask

  task automatic test_priority_idle();
    logic [31:0] init, held;
    init = $urandom;
    step0(1, 32'h104, 4'hF, 4'h0, init);
    held = dout0M;
    step0(1, 32'h104, 4'b0011, 4'hF, 32'h0000_BEEF);
    testsRun++;
    if (bus0.dout !== held) begin
      testsFailed++;
      $display("[TB] FAIL write_priority_dout: got %h expected %h", bus0.dout, held);
    end
    step0(0, 32'h104, 4'hF, 4'hF, $urandom);
    step0(1, 32'h104, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== {init[31:16], 16'hBEEF}) begin
      testsFailed++;
      $display("[TB] FAIL priority_idle_mem: got %h expected %h", bus0.dout, {init[31:16], 16'hBEEF});
    end
  endtask

  task automatic test_switch();
    swIn = 16'h1234;
    tick(); tick(); tick();
    swVisible = 16'h1234;
    step0(1, SW_A, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== 32'h0000_3412) begin
      testsFailed++;
      $display("[TB] FAIL switch_read: got %h expected 00003412", bus0.dout);
    end
    step0(1, SW_A, 4'hF, 4'h0, $urandom);
    step0(1, SW_A, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== 32'h0000_3412) begin
      testsFailed++;
      $display("[TB] FAIL switch_write_dropped: got %h expected 00003412", bus0.dout);
    end
    swIn = 16'hABCD;
    step0(1, SW_A, 4'h0, 4'hF, 32'h0);
    step0(1, SW_A, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== 32'h0000_3412) begin
      testsFailed++;
      $display("[TB] FAIL switch_latency_early: got %h expected 00003412", bus0.dout);
    end
    swVisible = 16'hABCD;
    step0(1, SW_A, 4'h0, 4'hF, 32'h0);
    testsRun++;
    if (bus0.dout !== 32'h0000_CDAB) begin
      testsFailed++;
      $display("[TB] FAIL switch_latency_late: got %h expected 0000cdab", bus0.dout);
    end
  endtask

  task automatic test_random_ram();
    int poolIdx [6];
    int sel, kind;
    logic [31:0] a;
    logic [3:0] w, r;
    for (int i = 0; i < 6; i++) begin
      poolIdx[i] = $urandom_range(0, 4095);
      a = ($urandom & 32'h7FFF_C000) | (32'(poolIdx[i]) << 2);
      step0(1, a, 4'hF, 4'h0, $urandom);
    end
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      kind = $urandom_range(0, 3);
      if (sel == 6) a = LED_A;
      else if (sel == 7) a = SEG_A;
      else a = ($urandom & 32'h7FFF_C000) | (32'(poolIdx[sel]) << 2) | 32'($urandom_range(0, 3));
      if (kind <= 1) begin
        w = 4'($urandom_range(1, 15)); r = 4'($urandom);
        step0(1, a, w, r, $urandom);
      end else if (kind == 2) begin
        r = 4'($urandom_range(1, 15));
        step0(1, a, 4'h0, r, $urandom);
      end else begin
        step0(0, a, 4'($urandom), 4'($urandom), $urandom);
      end
      testsRun++;
      if (bus0.dout !== dout0M) begin
        testsFailed++;
        $display("[TB] FAIL random_dout op %0d: got %h expected %h", n, bus0.dout, dout0M);
      end
      testsRun++;
      if (led0 !== {led0M[23:16], led0M[31:24]}) begin
        testsFailed++;
        $display("[TB] FAIL random_led op %0d: got %h expected %h", n, led0, {led0M[23:16], led0M[31:24]});
      end
      testsRun++;
      if (seg0 !== swap32(seg0M)) begin
        testsFailed++;
        $display("[TB] FAIL random_seg7 op %0d: got %h expected %h", n, seg0, swap32(seg0M));
      end
    end
  endtask

  task automatic test_wait();
    int stalls;
    bit early, timedOut;
    logic [31:0] d, ld;
    d = $urandom;
    run3(32'h100, 4'hF, 4'h0, d, stalls, early, timedOut);
    testsRun++;
    if (stalls != 3 || timedOut) begin
      testsFailed++;
      $display("[TB] FAIL wait_write_stalls: got %0d timeout %0b expected 3", stalls, timedOut);
    end
    run3(32'h100, 4'h0, 4'hF, 32'h0, stalls, early, timedOut);
    testsRun++;
    if (stalls != 3 || timedOut || early) begin
      testsFailed++;
      $display("[TB] FAIL wait_read_stalls: got %0d early %0b timeout %0b expected 3 0 0", stalls, early, timedOut);
    end
    testsRun++;
    if (bus3.dout !== d) begin
      testsFailed++;
      $display("[TB] FAIL wait_read_data: got %h expected %h", bus3.dout, d);
    end
    ld = $urandom;
    run3(LED_A, 4'hF, 4'h0, ld, stalls, early, timedOut);
    testsRun++;
    if (early || led3 !== {ld[23:16], ld[31:24]}) begin
      testsFailed++;
      $display("[TB] FAIL wait_led_commit: got %h early %0b expected %h", led3, early, {ld[23:16], ld[31:24]});
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    bit e1, e2, t1, t2;
    logic [31:0] d;
    d = $urandom;
    run3(32'h208, 4'hF, 4'h0, d, s1, e1, t1);
    run3(32'h208, 4'h0, 4'hF, 32'h0, s2, e2, t2);
    testsRun++;
    if (s1 != 3 || s2 != 3 || t1 || t2) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_stalls: got %0d,%0d expected 3,3", s1, s2);
    end
    testsRun++;
    if (bus3.dout !== d) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_data: got %h expected %h", bus3.dout, d);
    end
  endtask

  task automatic test_reset_mid_wait();
    int stalls;
    bit early, timedOut;
    logic [31:0] d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    led0M = 32'h0; seg0M = 32'h0; dout0M = 32'h0;
    d = {8'h80 | 8'($urandom), 8'h40 | 8'($urandom), 16'($urandom)};
    bus3.dce = 1'b1; bus3.daddr = LED_A; bus3.we = 4'hF; bus3.dre = 4'h0; bus3.din = d;
    tick();
    rst = 1'b1;
    #1;
    testsRun++;
    if (bus3.dstall !== 1'b0 || led3 !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_wait_immediate: got dstall %b led %h expected 0 0000", bus3.dstall, led3);
    end
    tick(); tick();
    testsRun++;
    if (bus3.dstall !== 1'b0 || led3 !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_wait_held: got dstall %b led %h expected 0 0000", bus3.dstall, led3);
    end
    rst = 1'b0;
    run3(LED_A, 4'hF, 4'h0, d, stalls, early, timedOut);
    testsRun++;
    if (stalls != 3 || early || timedOut) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_wait_restart: got %0d early %0b timeout %0b expected 3 0 0", stalls, early, timedOut);
    end
    testsRun++;
    if (led3 !== {d[23:16], d[31:24]}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_wait_led: got %h expected %h", led3, {d[23:16], d[31:24]});
    end
  endtask

  initial begin
    bus0.dce = 1'b0; bus0.daddr = 32'h0; bus0.we = 4'h0; bus0.dre = 4'h0; bus0.din = 32'h0;
    bus3.dce = 1'b0; bus3.daddr = 32'h0; bus3.we = 4'h0; bus3.dre = 4'h0; bus3.din = 32'h0;
    #2;
    test_reset();
    test_led();
    test_byte_lanes();
    test_priority_idle();
    test_switch();
    test_random_ram();
    test_wait();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
